updown_counter_fsm_p: RTL and testbench
=======================================

# updown_counter_fsm_p

Parametrised up/down counter with an explicit direction state machine, a programmable terminal value, selectable boundary behaviour (wrap, saturate, halt), synchronous load/clear, and registered overflow/underflow event pulses. It supersedes the fixed 4-bit FSM counter. It serves as the general-purpose event/position counter for control paths that need a modulo-N or bounded count with boundary reporting.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (>= 2)
- MAX_VAL, 2**WIDTH-1, terminal (upper) count value; legal range 1 .. 2**WIDTH-1
- MODE, 0, boundary behaviour: 0 = wrap, 1 = saturate, 2 = halt (sticky until clear/load)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value loaded when load = 1
- clear  input  1  synchronous clear to 0 and exit HALT
- count  output  WIDTH  current count, registered
- state  output  2  FSM state, registered: IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10, HALT = 2'b11
- ovf  output  1  one-cycle pulse, registered: an up-step was attempted at MAX_VAL
- unf  output  1  one-cycle pulse, registered: a down-step was attempted at 0
- halted  output  1  state == HALT
- at_max  output  1  count == MAX_VAL, combinational from count
- at_min  output  1  count == 0, combinational from count

## Operation
- Reset (highest priority): count = 0, state = IDLE, ovf = 0, unf = 0.
- At each rising edge, the first matching rule below applies. ovf and unf default to 0 every cycle.
  1. clear: count <= 0, state <= IDLE.
  2. load: count <= load_val, clamped to MAX_VAL if load_val > MAX_VAL; state <= IDLE.
  3. state == HALT: count, state and flags hold. enable and up are ignored.
  4. enable = 0: count holds, state <= IDLE.
  5. enable = 1, up = 1, count < MAX_VAL: count <= count+1, state <= UP.
  6. enable = 1, up = 1, count == MAX_VAL: ovf <= 1, plus the MODE action:
     - MODE 0: count <= 0, state <= UP.
     - MODE 1: count holds, state <= UP.
     - MODE 2: count holds, state <= HALT.
  7. enable = 1, up = 0, count > 0: count <= count-1, state <= DOWN.
  8. enable = 1, up = 0, count == 0: unf <= 1, plus the MODE action:
     - MODE 0: count <= MAX_VAL, state <= DOWN.
     - MODE 1: count holds at 0, state <= DOWN.
     - MODE 2: count holds at 0, state <= HALT.
- Direction may reverse on any cycle: UP <-> DOWN directly, with no pass through IDLE.
- In MODE 1, holding at a boundary with enable = 1 re-pulses ovf or unf on every cycle.
- In MODE 2, the pulse fires exactly once on entry to HALT.
- HALT is exited only by clear, load, or reset.
- Arithmetic is unsigned and WIDTH bits wide. count never exceeds MAX_VAL, including after load.
- Unused MODE values (3) behave as MODE 0.

## Timing
- Latency: every input takes effect on count/state/ovf/unf at the next rising edge (1 cycle).
- ovf and unf are asserted in the cycle after the edge that sampled the boundary step, for exactly one cycle per boundary step.
- halted, at_max and at_min follow the registered state/count with no additional cycle.
- Simultaneous clear and load: clear wins. Simultaneous load and enable: load wins, and no step is taken that cycle.
- Reset asserted mid-count or in HALT: the reset values above appear after that edge, regardless of the other inputs.

## Test plan
- WIDTH = 4, MAX_VAL = 9, MODE = 0; reset, then enable = 1, up = 1 for 12 cycles -> count 1..9, 0, 1, 2. ovf is high only in the cycle count reads 0. state = UP.
- Same config; load load_val = 0, then down 3 cycles -> count 9, 8, 7. unf pulses once with count = 9. state goes IDLE -> DOWN.
- MODE = 1, MAX_VAL = 9; count up 11 cycles from 0 -> count sticks at 9 and at_max = 1. ovf is high on each of the last 2 cycles.
- MODE = 2, MAX_VAL = 9:
  - Count up to 9, then one more step -> state = HALT, halted = 1, ovf single pulse.
  - Toggle enable and up for 5 cycles -> no change.
  - clear -> count 0, state IDLE.
- Priority: load_val = 15 with MAX_VAL = 9 -> count = 9. clear + load in the same cycle -> count 0. load + enable in the same cycle -> count = load_val, no step taken.
- Reset mid-operation: assert reset while count = 5 in state DOWN, with enable = 1 -> next cycle count 0, state IDLE, ovf = unf = 0.

Source files
------------

// File: rtl/updown_counter_fsm_p.sv
// Parametrised up/down counter with a direction FSM, programmable terminal value,
// selectable boundary behaviour (wrap/saturate/halt) and registered ovf/unf pulses.
module updown_counter_fsm_p #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1,
  parameter int unsigned MODE    = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count,
  output logic [1:0]       o_state,
  output logic             o_ovf,
  output logic             o_unf,
  output logic             o_halted,
  output logic             o_at_max,
  output logic             o_at_min
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10,
    S_HALT = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] C_MAX = MAX_VAL[WIDTH-1:0];
  // MODE 3 is treated as wrap, so only saturate and halt need flags.
  localparam bit C_SAT  = (MODE == 1);
  localparam bit C_HALT = (MODE == 2);

  logic [WIDTH-1:0] r_count;
  state_t           r_state;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_count_nxt;
  state_t           w_state_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;

  always_comb begin
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    w_ovf_nxt   = 1'b0;
    w_unf_nxt   = 1'b0;
    if (i_clear) begin
      w_count_nxt = '0;
      w_state_nxt = S_IDLE;
    end else if (i_load) begin
      w_count_nxt = (i_load_val > C_MAX) ? C_MAX : i_load_val;
      w_state_nxt = S_IDLE;
    end else if (r_state == S_HALT) begin
      w_state_nxt = S_HALT;
    end else if (!i_enable) begin
      w_state_nxt = S_IDLE;
    end else if (i_up) begin
      if (r_count < C_MAX) begin
        w_count_nxt = r_count + 1'b1;
        w_state_nxt = S_UP;
      end else begin
        w_ovf_nxt = 1'b1;
        if (C_HALT) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_UP;
          if (!C_SAT) w_count_nxt = '0;
        end
      end
    end else begin
      if (r_count > '0) begin
        w_count_nxt = r_count - 1'b1;
        w_state_nxt = S_DOWN;
      end else begin
        w_unf_nxt = 1'b1;
        if (C_HALT) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_DOWN;
          if (!C_SAT) w_count_nxt = C_MAX;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
      r_state <= S_IDLE;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  assign o_count  = r_count;
  assign o_state  = r_state;
  assign o_ovf    = r_ovf;
  assign o_unf    = r_unf;
  assign o_halted = (r_state == S_HALT);
  assign o_at_max = (r_count == C_MAX);
  assign o_at_min = (r_count == '0);

endmodule

// File: tb/tb_updown_counter_fsm_p.sv
// Bench for updown_counter_fsm_p: three instances (wrap, saturate, halt) with WIDTH=4,
// MAX_VAL=9 share one stimulus; a vector table covers wrap mode, hand sequences the rest.
module tb_updown_counter_fsm_p;

  localparam logic [1:0] IDLE = 2'b00, UP = 2'b01, DN = 2'b10, HALT = 2'b11;
  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       reset, enable, up, load, clear;
  logic [3:0] load_val;

  logic [3:0] cnt [3];
  logic [1:0] st  [3];
  logic       ovf [3];
  logic       unf [3];
  logic       hlt [3];
  logic       amax[3];
  logic       amin[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    updown_counter_fsm_p #(.WIDTH(4), .MAX_VAL(MAXV), .MODE(g)) u_dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_enable   (enable),
      .i_up       (up),
      .i_load     (load),
      .i_load_val (load_val),
      .i_clear    (clear),
      .o_count    (cnt[g]),
      .o_state    (st[g]),
      .o_ovf      (ovf[g]),
      .o_unf      (unf[g]),
      .o_halted   (hlt[g]),
      .o_at_max   (amax[g]),
      .o_at_min   (amin[g])
    );
  end

  typedef struct {
    logic       en, dir, ld;
    logic [3:0] ldv;
    logic       clr, rst;
    logic [3:0] c;
    logic [1:0] s;
    logic       o, u;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic dir, logic ld, logic [3:0] ldv, logic clr,
                              logic rst, logic [3:0] c, logic [1:0] s, logic o, logic u);
    vec_t v;
    v.en = en; v.dir = dir; v.ld = ld; v.ldv = ldv; v.clr = clr; v.rst = rst;
    v.c = c; v.s = s; v.o = o; v.u = u;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_dut(string nm, int sel, int c, int s, int o, int u);
    chk({nm, " count"}, cnt[sel], c);
    chk({nm, " state"}, st[sel], s);
    chk({nm, " ovf"}, ovf[sel], o);
    chk({nm, " unf"}, unf[sel], u);
    chk({nm, " halted"}, hlt[sel], (s == HALT) ? 1 : 0);
    chk({nm, " at_max"}, amax[sel], (c == MAXV) ? 1 : 0);
    chk({nm, " at_min"}, amin[sel], (c == 0) ? 1 : 0);
  endtask

  task automatic apply(logic en, logic dir, logic ld, logic [3:0] ldv, logic clr, logic rst);
    enable = en; up = dir; load = ld; load_val = ldv; clear = clr; reset = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    enable = 0; up = 0; load = 0; load_val = 0; clear = 0; reset = 1;
    apply(0, 0, 0, 0, 0, 1);
    apply(1, 1, 1, 4'd7, 0, 1);
    for (int g = 0; g < 3; g++) chk_dut($sformatf("reset m%0d", g), g, 0, IDLE, 0, 0);

    // Wrap-mode vector table (MODE 0 instance).
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4'(i), UP, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 0, UP,   1, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 1, UP,   0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 2, UP,   0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  0, 0, 0, IDLE, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 9, DN,   0, 1));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 8, DN,   0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 7, DN,   0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 7, IDLE, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 8, UP,   0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 7, DN,   0, 0));
    tbl.push_back(mk(0, 0, 1, 15, 0, 0, 9, IDLE, 0, 0));
    tbl.push_back(mk(0, 0, 1, 10, 0, 0, 9, IDLE, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4,  0, 0, 4, IDLE, 0, 0));
    tbl.push_back(mk(0, 0, 1, 7,  1, 0, 0, IDLE, 0, 0));
    tbl.push_back(mk(0, 0, 1, 9,  0, 0, 9, IDLE, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 0, UP,   1, 0));
    tbl.push_back(mk(0, 0, 1, 6,  0, 0, 6, IDLE, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 5, DN,   0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 1, 0, IDLE, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 9, DN,   0, 1));
    tbl.push_back(mk(1, 1, 0, 0,  0, 1, 0, IDLE, 0, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].en, tbl[i].dir, tbl[i].ld, tbl[i].ldv, tbl[i].clr, tbl[i].rst);
      chk_dut($sformatf("wrap vec%0d", i), 0, tbl[i].c, tbl[i].s, tbl[i].o, tbl[i].u);
    end

    // Saturate: 11 up-steps from 0 stick at 9, ovf on the last two.
    apply(0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 11; i++) begin
      apply(1, 1, 0, 0, 0, 0);
      chk_dut($sformatf("sat up%0d", i), 1, (i > 9) ? 9 : i, UP, (i > 9) ? 1 : 0, 0);
    end
    apply(0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 2; i++) begin
      apply(1, 0, 0, 0, 0, 0);
      chk_dut($sformatf("sat dn%0d", i), 1, 0, DN, 0, 1);
    end

    // Halt: ovf once on entry, inputs ignored, clear exits.
    apply(0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 9; i++) apply(1, 1, 0, 0, 0, 0);
    chk_dut("halt pre", 2, 9, UP, 0, 0);
    apply(1, 1, 0, 0, 0, 0);
    chk_dut("halt entry", 2, 9, HALT, 1, 0);
    for (int i = 0; i < 5; i++) begin
      apply(logic'(i % 2), logic'((i / 2) % 2), 0, 0, 0, 0);
      chk_dut($sformatf("halt hold%0d", i), 2, 9, HALT, 0, 0);
    end
    apply(1, 1, 0, 0, 1, 0);
    chk_dut("halt clear", 2, 0, IDLE, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    chk_dut("halt unf entry", 2, 0, HALT, 0, 1);
    apply(1, 0, 0, 0, 0, 0);
    chk_dut("halt unf hold", 2, 0, HALT, 0, 0);
    apply(1, 1, 1, 3, 0, 0);
    chk_dut("halt load exit", 2, 3, IDLE, 0, 0);
    apply(1, 1, 0, 0, 0, 0);
    chk_dut("halt resume", 2, 4, UP, 0, 0);
    apply(0, 0, 1, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    chk_dut("halt again", 2, 0, HALT, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    chk_dut("halt reset", 2, 0, IDLE, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
